// File: rtl/klavye_kontrolcu_gen2.sv
// klavye_kontrolcu_gen2 -- PS/2 set-2 scan code to ASCII converter with output FIFO.
//   Decodes key codes (letters, digits, space, enter, keypad under num-lock),
//   tracks shift level plus caps/num lock toggles, and queues ASCII characters
//   into a FIFO read by a valid/ready consumer.
// Optional feature: define KLAVYE_AUTO_REPEAT_EN to enable held-key auto-repeat.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   buton_aktif, buton_giris      key code valid level and scan code
//   kontrol_aktif, kontrol_giris  control code valid level and scan code
//   cikis_hazir                   consumer ready (pops head when cikis_aktif=1)
//   tasma_temizle                 clears sticky overflow flag
//   caps_lock, num_lock           lock states
//   cikis_aktif, cikis            FIFO non-empty and head character (0 when empty)
//   doluluk                       FIFO occupancy
//   tasma                         sticky overflow flag
module klavye_kontrolcu_gen2 #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned REPEAT_DELAY  = 50,
  parameter int unsigned REPEAT_PERIOD = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          buton_aktif,
  input  logic [7:0]                    buton_giris,
  input  logic                          kontrol_aktif,
  input  logic [7:0]                    kontrol_giris,
  input  logic                          cikis_hazir,
  input  logic                          tasma_temizle,
  output logic                          caps_lock,
  output logic                          num_lock,
  output logic                          cikis_aktif,
  output logic [7:0]                    cikis,
  output logic [$clog2(FIFO_DEPTH):0]   doluluk,
  output logic                          tasma
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  // Scan code to ASCII; bit 8 flags a valid mapping under current lock/shift state.
  function automatic logic [8:0] f_map(input logic [7:0] code, input logic upper,
                                       input logic num_on);
    logic [7:0] ch;
    ch = 8'h00;
    case (code)
      8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
      8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
      8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
      8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
      8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
      8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
      8'h35: ch = "y";  8'h1A: ch = "z";
      8'h45: ch = "0";  8'h16: ch = "1";  8'h1E: ch = "2";  8'h26: ch = "3";
      8'h25: ch = "4";  8'h2E: ch = "5";  8'h36: ch = "6";  8'h3D: ch = "7";
      8'h3E: ch = "8";  8'h46: ch = "9";
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0D;
      8'h70: ch = num_on ? "0" : 8'h00;  8'h69: ch = num_on ? "1" : 8'h00;
      8'h72: ch = num_on ? "2" : 8'h00;  8'h7A: ch = num_on ? "3" : 8'h00;
      8'h6B: ch = num_on ? "4" : 8'h00;  8'h73: ch = num_on ? "5" : 8'h00;
      8'h74: ch = num_on ? "6" : 8'h00;  8'h6C: ch = num_on ? "7" : 8'h00;
      8'h75: ch = num_on ? "8" : 8'h00;  8'h7D: ch = num_on ? "9" : 8'h00;
      default: ch = 8'h00;
    endcase
    if (upper && ch >= "a" && ch <= "z") ch = ch - 8'h20;
    return {(ch != 8'h00), ch};
  endfunction

  logic            r_prev_aktif;
  logic [7:0]      r_prev_code;
  logic            r_caps_det, r_num_det;
  logic            r_caps, r_num;
  logic            r_evt_vld;
  logic [7:0]      r_evt_chr;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_count;
  logic            r_cikis_aktif;
  logic [7:0]      r_cikis;
  logic            r_tasma;

  logic            w_shift, w_caps_det, w_num_det, w_hold, w_press, w_evt;
  logic [8:0]      w_map;

  // Key decode uses the lock values held before this sample's toggle.
  assign w_shift    = kontrol_aktif && (kontrol_giris == 8'h12 || kontrol_giris == 8'h59);
  assign w_caps_det = kontrol_aktif && (kontrol_giris == 8'h58);
  assign w_num_det  = kontrol_aktif && (kontrol_giris == 8'h77);
  assign w_map      = f_map(buton_giris, w_shift ^ r_caps, r_num);
  assign w_hold     = buton_aktif && r_prev_aktif && (buton_giris == r_prev_code);
  assign w_press    = buton_aktif && w_map[8] && !w_hold;

`ifdef KLAVYE_AUTO_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {BOS, BEKLE, TEKRAR} rpt_e;
  rpt_e            r_state, w_state_nxt;
  logic [RW-1:0]   r_rcnt, w_rcnt_nxt;
  logic            w_rpt;

  // Repeat state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOS;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  // Repeat next-state: counts held samples since press / last repeat.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rpt       = 1'b0;
    case (r_state)
      BOS: begin
        if (w_press) begin
          w_state_nxt = BEKLE;
          w_rcnt_nxt  = '0;
        end
      end
      BEKLE, TEKRAR: begin
        if (!w_hold) begin
          w_state_nxt = w_press ? BEKLE : BOS;
          w_rcnt_nxt  = '0;
        end else if (r_rcnt == RW'((r_state == BEKLE) ? REPEAT_DELAY - 1 : REPEAT_PERIOD - 1)) begin
          w_state_nxt = TEKRAR;
          w_rcnt_nxt  = '0;
          w_rpt       = w_map[8];
        end else begin
          w_rcnt_nxt  = r_rcnt + 1'b1;
        end
      end
      default: w_state_nxt = BOS;
    endcase
  end

  assign w_evt = w_press || w_rpt;
`else
  assign w_evt = w_press;
`endif

  // Input sampling, lock toggles and event stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_aktif <= 1'b0;
      r_prev_code  <= 8'h00;
      r_caps_det   <= 1'b0;
      r_num_det    <= 1'b0;
      r_caps       <= 1'b0;
      r_num        <= 1'b0;
      r_evt_vld    <= 1'b0;
      r_evt_chr    <= 8'h00;
    end else begin
      r_prev_aktif <= buton_aktif;
      r_prev_code  <= buton_giris;
      r_caps_det   <= w_caps_det;
      r_num_det    <= w_num_det;
      if (w_caps_det && !r_caps_det) r_caps <= !r_caps;
      if (w_num_det && !r_num_det)   r_num  <= !r_num;
      r_evt_vld    <= w_evt;
      r_evt_chr    <= w_map[7:0];
    end
  end

  logic            w_pop, w_full, w_wr, w_ovf;
  logic [AW-1:0]   w_rd_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [7:0]      w_head_nxt;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_pop       = r_cikis_aktif && cikis_hazir;
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_wr        = r_evt_vld && (!w_full || w_pop);
  assign w_ovf       = r_evt_vld && w_full && !w_pop;
  assign w_rd_nxt    = w_pop ? r_rd + 1'b1 : r_rd;
  assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);
  // The new entry becomes the head when it lands at the next read slot.
  assign w_head_nxt  = (w_wr && (r_wr == w_rd_nxt)) ? r_evt_chr : r_mem[w_rd_nxt];

  // FIFO storage (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= r_evt_chr;
  end

  // FIFO control and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr          <= '0;
      r_rd          <= '0;
      r_count       <= '0;
      r_cikis_aktif <= 1'b0;
      r_cikis       <= 8'h00;
      r_tasma       <= 1'b0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      r_rd          <= w_rd_nxt;
      r_count       <= w_count_nxt;
      r_cikis_aktif <= (w_count_nxt != '0);
      r_cikis       <= (w_count_nxt != '0) ? w_head_nxt : 8'h00;
      if (w_ovf)              r_tasma <= 1'b1;
      else if (tasma_temizle) r_tasma <= 1'b0;
    end
  end

  assign caps_lock   = r_caps;
  assign num_lock    = r_num;
  assign cikis_aktif = r_cikis_aktif;
  assign cikis       = r_cikis;
  assign doluluk     = r_count;
  assign tasma       = r_tasma;

endmodule

// File: tb/tb_klavye_kontrolcu_gen2.sv
// Scoreboard bench for klavye_kontrolcu_gen2: stimulus pushes expected ASCII,
// a negedge monitor pops and compares on every handshake.
module tb_klavye_kontrolcu_gen2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       buton_aktif;
  logic [7:0] buton_giris;
  logic       kontrol_aktif;
  logic [7:0] kontrol_giris;
  logic       cikis_hazir;
  logic       tasma_temizle;
  logic       caps_lock, num_lock, cikis_aktif, tasma;
  logic [7:0] cikis;
  logic [3:0] doluluk;

  int         n_checks = 0;
  int         n_err    = 0;
  int         active_cnt = 0;
  logic [7:0] q [$];
  logic [7:0] exp_chr;

  logic [7:0] c9 [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
  logic [7:0] d8 [8] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};

  klavye_kontrolcu_gen2 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .buton_aktif   (buton_aktif),
    .buton_giris   (buton_giris),
    .kontrol_aktif (kontrol_aktif),
    .kontrol_giris (kontrol_giris),
    .cikis_hazir   (cikis_hazir),
    .tasma_temizle (tasma_temizle),
    .caps_lock     (caps_lock),
    .num_lock      (num_lock),
    .cikis_aktif   (cikis_aktif),
    .cikis         (cikis),
    .doluluk       (doluluk),
    .tasma         (tasma)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got=%0h required=%0h at %0t", name, got, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [7:0] code, input int n);
    buton_giris = code;
    buton_aktif = 1'b1;
    tick(n);
    buton_aktif = 1'b0;
    tick(1);
  endtask

  task automatic ctrl_pulse(input logic [7:0] code);
    kontrol_aktif = 1'b1;
    kontrol_giris = code;
    tick(1);
    kontrol_aktif = 1'b0;
    tick(1);
  endtask

  // Monitor: every handshake must match the oldest expected character.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (cikis_aktif) active_cnt++;
      else chk("idle_zero", 32'(cikis), 32'h0);
      if (cikis_aktif && cikis_hazir) begin
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_out: got=%0h required=none at %0t", cikis, $time);
        end else begin
          exp_chr = q.pop_front();
          chk("char", 32'(cikis), 32'(exp_chr));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; buton_aktif = 1'b0; buton_giris = 8'h00;
    kontrol_aktif = 1'b0; kontrol_giris = 8'h00;
    cikis_hazir = 1'b1; tasma_temizle = 1'b0;
    tick(3);
    chk("rst_caps", 32'(caps_lock), 0);
    chk("rst_num", 32'(num_lock), 0);
    chk("rst_aktif", 32'(cikis_aktif), 0);
    chk("rst_cikis", 32'(cikis), 0);
    chk("rst_doluluk", 32'(doluluk), 0);
    chk("rst_tasma", 32'(tasma), 0);
    rst_n = 1'b1;
    tick(2);

    // Single press, valid exactly one cycle with consumer ready.
    active_cnt = 0;
    q.push_back(8'h74);
    key(8'h2C, 1);
    tick(5);
    chk("t_active_cycles", 32'(active_cnt), 1);

    // Shift level, caps toggle, unmapped code, shift XOR caps.
    kontrol_aktif = 1'b1; kontrol_giris = 8'h12;
    q.push_back("O");
    key(8'h44, 1);
    kontrol_giris = 8'h58; tick(1); kontrol_giris = 8'h12;
    key(8'h4C, 1);
    q.push_back("a");
    key(8'h1C, 1);
    kontrol_aktif = 1'b0; tick(1);
    chk("caps_on", 32'(caps_lock), 1);
    ctrl_pulse(8'h58);
    chk("caps_off", 32'(caps_lock), 0);

    // Key and caps toggle in the same sample use pre-toggle caps.
    kontrol_aktif = 1'b1; kontrol_giris = 8'h58;
    q.push_back("b");
    key(8'h32, 2);
    kontrol_aktif = 1'b0; tick(1);
    chk("caps_same_sample", 32'(caps_lock), 1);
    q.push_back("B");
    key(8'h32, 1);
    ctrl_pulse(8'h58);

    // Keypad gated by num-lock.
    key(8'h6C, 1);
    chk("num_off", 32'(num_lock), 0);
    ctrl_pulse(8'h77);
    chk("num_on", 32'(num_lock), 1);
    q.push_back("7");
    key(8'h6C, 1);
    q.push_back("0");
    key(8'h70, 1);
    ctrl_pulse(8'h77);
    chk("num_off2", 32'(num_lock), 0);

    // Second shift code: digits/space/enter unchanged, letters upper.
    kontrol_aktif = 1'b1; kontrol_giris = 8'h59;
    q.push_back("1");   key(8'h16, 1);
    q.push_back(8'h20); key(8'h29, 1);
    q.push_back(8'h0D); key(8'h5A, 1);
    q.push_back("Z");   key(8'h1A, 1);
    kontrol_aktif = 1'b0;

    // Code change without release is a new press.
    q.push_back("a"); q.push_back("b");
    buton_giris = 8'h1C; buton_aktif = 1'b1; tick(1);
    buton_giris = 8'h32; tick(1);
    buton_aktif = 1'b0; tick(4);

    // Overflow: 9 presses with consumer stalled, set+clear keeps tasma.
    cikis_hazir = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) q.push_back(8'("a") + 8'(i));
      key(c9[i], 1);
    end
    tick(2);
    chk("full_doluluk", 32'(doluluk), 8);
    chk("ovf_tasma", 32'(tasma), 1);
    tasma_temizle = 1'b1;
    key(8'h3B, 1);
    tasma_temizle = 1'b0;
    chk("tasma_set_clr", 32'(tasma), 1);
    tasma_temizle = 1'b1; tick(1); tasma_temizle = 1'b0;
    chk("tasma_clr", 32'(tasma), 0);
    cikis_hazir = 1'b1;
    tick(12);
    chk("drained", 32'(doluluk), 0);

    // Write into a full FIFO with same-cycle pop is accepted.
    cikis_hazir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      q.push_back(8'("0") + 8'(i));
      key(d8[i], 1);
    end
    tick(2);
    chk("full2_doluluk", 32'(doluluk), 8);
    q.push_back("8");
    buton_giris = 8'h3E; buton_aktif = 1'b1; tick(1);
    buton_aktif = 1'b0; cikis_hazir = 1'b1; tick(1);
    chk("full_pop_write", 32'(doluluk), 8);
    chk("full_pop_tasma", 32'(tasma), 0);
    tick(12);
    chk("drained2", 32'(doluluk), 0);

    // Reset discards pending data; key held across release gives one press.
    cikis_hazir = 1'b0;
    key(8'h1C, 1);
    key(8'h32, 1);
    tick(2);
    chk("pre_rst_doluluk", 32'(doluluk), 2);
    buton_giris = 8'h21; buton_aktif = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_doluluk", 32'(doluluk), 0);
    chk("rst_mid_aktif", 32'(cikis_aktif), 0);
    tick(3);
    q.push_back("c");
    cikis_hazir = 1'b1;
    rst_n = 1'b1;
    tick(3);
    buton_aktif = 1'b0;
    tick(4);

    // Long hold of space: auto-repeat only when the feature is built in.
`ifdef KLAVYE_AUTO_REPEAT_EN
    repeat (4) q.push_back(8'h20);
`else
    q.push_back(8'h20);
`endif
    key(8'h29, 75);
    tick(6);

    chk("leftover_expected", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/klavye_kontrolcu_gen2.md
KLAVYE_KONTROLCU_GEN2 -- requirements
Module: klavye_kontrolcu_gen2

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output-FIFO entries; SHALL be a power of 2, >=2.
REQ-002 Parameter REPEAT_DELAY, default 50, cycles from press to first auto-repeat.
REQ-003 Parameter REPEAT_PERIOD, default 10, cycles between subsequent auto-repeats.
REQ-004 Ports SHALL be:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  buton_aktif  in  1  key-code valid level.
  buton_giris  in  8  PS/2 set-2 key scan code.
  kontrol_aktif  in  1  control-code valid level.
  kontrol_giris  in  8  control scan code (0x12/0x59 shift, 0x58 caps, 0x77 num).
  cikis_hazir  in  1  consumer ready.
  tasma_temizle  in  1  clears tasma.
  caps_lock  out  1  caps-lock state.
  num_lock  out  1  num-lock state.
  cikis_aktif  out  1  FIFO non-empty (valid).
  cikis  out  8  ASCII at FIFO head; 0x00 when cikis_aktif=0.
  doluluk  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
  tasma  out  1  sticky overflow flag.

Function
REQ-005 All inputs SHALL be sampled on rising clk; no combinational input-to-output path.
REQ-006 Shift SHALL be a level: kontrol_aktif=1 and kontrol_giris in {0x12,0x59} in the sampling cycle.
REQ-007 caps_lock SHALL toggle once per rising edge of (kontrol_aktif and kontrol_giris==0x58); num_lock likewise with 0x77; held codes SHALL NOT re-toggle.
REQ-008 Press event: buton_aktif=1, code mapped, and previous sample had buton_aktif=0 or a different code.
REQ-009 Map: letters a-z = 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A; digits 0-9 = 45 16 1E 26 25 2E 36 3D 3E 46; 0x29 -> 0x20; 0x5A -> 0x0D.
REQ-010 Letters SHALL be uppercase iff shift XOR caps_lock; digits, space, enter unaffected by shift.
REQ-011 Keypad 0-9 = 70 69 72 7A 6B 73 74 6C 75 7D -> ASCII '0'-'9' only when num_lock=1; otherwise no event.
REQ-012 Unmapped codes SHALL produce no event and no FIFO write.
REQ-013 Key and lock toggle in same sample: key SHALL use the pre-toggle lock value.
REQ-014 Latency: event sampled at edge k SHALL be written at edge k+1; cikis_aktif=1 after edge k+1 if FIFO was empty.
REQ-015 Pop on cikis_aktif=1 and cikis_hazir=1; FIFO order preserved; pointers wrap modulo FIFO_DEPTH.
REQ-016 Write when full with no pop SHALL be dropped and set tasma; write when full with same-cycle pop SHALL be accepted.
REQ-017 Pop when empty SHALL be ignored; doluluk SHALL never exceed FIFO_DEPTH.
REQ-018 tasma SHALL clear on tasma_temizle=1; simultaneous set and clear SHALL leave tasma=1.

Reset
REQ-019 rst_n=0 SHALL asynchronously force caps_lock=0, num_lock=0, cikis_aktif=0, cikis=0x00, doluluk=0, tasma=0, repeat FSM to BOS, previous-sample registers to "no key".
REQ-020 A key held across reset release SHALL produce one press event at the first sample after release.
REQ-021 Reset mid-repeat or with FIFO non-empty SHALL discard all pending data.

Configuration
REQ-022 Macro KLAVYE_AUTO_REPEAT_EN: when defined, repeat FSM BOS->BEKLE on press; BEKLE->TEKRAR after REPEAT_DELAY samples emitting one event; TEKRAR emits every REPEAT_PERIOD samples; any release or code change -> BOS (new code -> BEKLE).
REQ-023 Repeat events SHALL recompute case from current shift/caps state.
REQ-024 Without KLAVYE_AUTO_REPEAT_EN: held key SHALL produce exactly one event; no repeat counters synthesised.

Verification
REQ-025 Press 0x2C one cycle, cikis_hazir=1 -> one 0x74 't', cikis_aktif high exactly one cycle.
REQ-026 Shift 0x12 held, key 0x44 -> 0x4F 'O'; then caps 0x58 pulse with shift held, key 0x4C -> 0x3B? no: 0x4C unmapped -> no output, caps_lock=1.
REQ-027 Key 0x32 with 0x58 same sample, held 2 cycles -> single 0x62 'b', caps_lock=1; next press 0x32 -> 0x42 'B'.
REQ-028 num_lock=0, key 0x6C -> nothing; pulse 0x77, key 0x6C -> 0x37 '7'.
REQ-029 cikis_hazir=0, 9 distinct presses (defaults) -> doluluk=8, tasma=1, first 8 chars drained in order.
REQ-030 KLAVYE_AUTO_REPEAT_EN, 0x29 held 75 cycles -> 0x20 at press, +50, +60, +70 (4 total); without macro -> 1.
